// File: rtl/lfsr_counter_pkg.sv
// Shared width, seed and feedback mask for the 8-bit Galois LFSR counter.
package lfsr_counter_pkg;
  localparam int LFSR_W = 8;
  typedef logic [LFSR_W-1:0] lfsr_t;
  localparam lfsr_t LFSR_SEED = 8'h01;
  localparam lfsr_t LFSR_MASK = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1
endpackage

// File: rtl/galois_lfsr_step.sv
// One right-shift Galois step; an all-zero state maps back to the seed.
module galois_lfsr_step
  import lfsr_counter_pkg::*;
(
  input  lfsr_t cur_i,
  output lfsr_t nxt_o,
  output logic  lockup_o
);
  always_comb begin
    lockup_o = (cur_i == '0);
    nxt_o    = (cur_i >> 1) ^ (cur_i[0] ? LFSR_MASK : '0);
    if (lockup_o) nxt_o = LFSR_SEED;
  end
endmodule

// File: rtl/top.sv
// Free-running 8-bit pseudo-random counter: state register, enable mux, async reset.
module top
  import lfsr_counter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              count,
  output logic [LFSR_W-1:0] Q
);
  lfsr_t q_q, q_d, step_nxt;
  logic  lockup;

  galois_lfsr_step u_step (
    .cur_i    (q_q),
    .nxt_o    (step_nxt),
    .lockup_o (lockup)
  );

  // Lock-up recovery must not depend on the enable, so it bypasses count.
  always_comb begin
    q_d = q_q;
    if (count || lockup) q_d = step_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign Q = q_q;
endmodule

// File: tb/tb_top.sv
// Directed bench for the LFSR counter: reset, sequence, hold, period, recovery.
module tb_top;
  logic       clk = 1'b0;
  logic       rst;
  logic       count;
  logic [7:0] Q;
  int         errors = 0;
  int         checks = 0;
  bit         seen [256];
  logic [7:0] held;
  logic [7:0] exp_seq [7];

  top dut (.clk(clk), .rst(rst), .count(count), .Q(Q));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input bit obs);
    checks++;
    assert (obs === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed=0 expected=1 (Q=%h)", tag, Q);
    end
  endtask

  initial begin
    exp_seq[0] = 8'h01; exp_seq[1] = 8'hB8; exp_seq[2] = 8'h5C; exp_seq[3] = 8'h2E;
    exp_seq[4] = 8'h17; exp_seq[5] = 8'hB3; exp_seq[6] = 8'hE1;

    // Reset held 20 ns with count low.
    rst = 1'b1; count = 1'b0;
    #20;
    check("reset_q", Q, 8'h01);
    // count high during reset must be ignored across edges.
    count = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_wins", Q, 8'h01);

    // Release and walk the first steps.
    rst = 1'b0;
    check("release_no_edge", Q, 8'h01);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("seq_%0d", i), Q, exp_seq[i]);
    end

    // Hold for 5 cycles, then resume.
    count = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), Q, 8'hE1);
    end
    count = 1'b1;
    @(negedge clk); check("resume_1", Q, 8'hC8);
    @(negedge clk); check("resume_2", Q, 8'h64);

    // Asynchronous mid-run reset between edges.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_reset", Q, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); check("restart_1", Q, 8'hB8);
    @(negedge clk); check("restart_2", Q, 8'h5C);

    // Full period from reset: 254 distinct nonzero values, then back to seed.
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (i < 255) begin
        check_bit($sformatf("period_fresh_%0d", i), (Q != 8'h00) && !seen[Q]);
        seen[Q] = 1'b1;
      end else begin
        check("period_wrap", Q, 8'h01);
      end
    end
    @(negedge clk); check("wrap_no_gap", Q, 8'hB8);

    // Long run then stop: value must hold.
    repeat (200) @(negedge clk);
    count = 1'b0;
    @(negedge clk);
    held = Q;
    check_bit("long_run_nonzero", held != 8'h00);
    repeat (5) @(negedge clk);
    check("long_hold", Q, held);

    // Upset to zero with count low: next edge reloads seed.
    force dut.q_q = 8'h00;
    #1;
    release dut.q_q;
    check("forced_zero", Q, 8'h00);
    @(negedge clk);
    check("zero_recover", Q, 8'h01);
    @(negedge clk);
    check("recover_then_hold", Q, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
